wb_itr_chk: RTL and testbench
=============================

// Module: wb_itr_chk
// PURPOSE
//  Synthesizable checker for a pipelined Wishbone initiator port. Tracks outstanding requests
//  (multiple requests in flight), flags protocol violations in sticky bits and times out stalls
//  and missing acknowledges. Taps a bus between initiator and target/crossbar; drives no bus signal.
// PARAMETERS
//  ADR_WIDTH   16  address bus width
//  DAT_WIDTH   16  write data bus width
//  SEL_WIDTH    2  number of data select lines
//  MAX_OUTST    4  max requests in flight (>=1); CNT_WIDTH = $clog2(MAX_OUTST+1) (localparam)
//  TO_WIDTH     8  width of timeout counters
//  STALL_TO    16  cycles of stalled request before STALL_TO flag; 0 disables
//  ACK_TO      64  cycles without termination while outst>0 before ACK_TO flag; 0 disables
// PORTS
//  clk_i        in   1          module clock
//  async_rst_i  in   1          asynchronous reset, active-high
//  sync_rst_i   in   1          synchronous reset, active-high
//  clr_i        in   1          synchronous clear of viol_o/irq_o only
//  itr_cyc_i    in   1          bus cycle indicator
//  itr_stb_i    in   1          access request
//  itr_we_i     in   1          write enable
//  itr_sel_i    in   SEL_WIDTH  write data selects
//  itr_adr_i    in   ADR_WIDTH  address bus
//  itr_dat_i    in   DAT_WIDTH  write data bus
//  itr_ack_o    in   1          acknowledge (target->initiator, observed)
//  itr_err_o    in   1          error (observed)
//  itr_rty_o    in   1          retry (observed)
//  itr_stall_o  in   1          stall (observed)
//  outst_o      out  CNT_WIDTH  requests in flight
//  busy_o       out  1          FSM in BUSY
//  viol_o       out  8          sticky violation flags
//  irq_o        out  1          registered |viol_o
// BEHAVIOUR
//  Reset: clk_i; async_rst_i async, sync_rst_i sync; both -> FSM RESET, outst_o=0, busy_o=0,
//   viol_o=0, irq_o=0, timeout counters=0, stall capture invalid. All outputs registered.
//  req = cyc&stb&~stall; term = ack|err|rty. Counter: +req -term same cycle; req&term -> unchanged.
//   Saturates at MAX_OUTST (on overflow) and 0 (on underflow); updates visible 1 cycle later.
//  FSM: RESET -> IDLE unconditionally; IDLE -> BUSY on cyc; BUSY -> IDLE on ~cyc.
//   On ~cyc outst_o clears to 0 next cycle (abort); later terminations count as spurious.
//  viol_o bits (set the cycle after the event, hold until reset or clr_i; clr_i&new event -> set wins):
//   [0] MULTI_TERM  more than one of ack/err/rty high
//   [1] SPURIOUS    term while outst==0 and ~req (zero-latency term with req is legal)
//   [2] OVERFLOW    req while outst==MAX_OUTST and ~term
//   [3] ABORT       cyc falls while outst>0 (informational; counter cleared)
//   [4] STALL_TO    cyc&stb&stall for STALL_TO consecutive cycles
//   [5] ACK_TO      outst>0 and ~term for ACK_TO consecutive cycles (counter resets on term)
//   [6] RST_ACT     cyc or stb high while FSM in RESET
//   [7] STALL_CHG   stalled request prev cycle (cyc&stb&stall) and now stb low, or adr/we/sel
//                   changed, or dat changed with we=1
//  Timeout counters saturate at TO_WIDTH max; flag fires once per expiry; any reset clears.
//  irq_o = |viol_o registered (1 cycle after viol_o bit rises).
// TESTING
//  3 back-to-back reqs adr 0x10,0x12,0x14 no stall, acks 2 cycles later -> outst 1,2,3,2,1,0; viol_o=0
//  MAX_OUTST=4: 5 reqs, no term -> outst_o holds 4; viol_o[2]=1; irq_o=1 next cycle
//  ack&err same cycle with outst=1 -> viol_o=0x01; clr_i pulse -> viol_o=0x00, irq_o=0
//  STALL_TO=16: req stalled 16 cycles, adr held 0x20 -> viol_o[4]=1; adr 0x20->0x22 while stalled -> [7]
//  2 reqs then cyc dropped -> viol_o[3]=1, outst_o=0; ack next cycle -> viol_o[1]=1
//  async_rst_i pulsed mid-burst (outst=3) -> all outputs 0 immediately; cyc high in RESET -> viol_o[6]

Source files
------------

// File: rtl/wb_itr_chk.sv
// Passive checker for a pipelined Wishbone initiator port: outstanding-request tracking, sticky violation flags, timeouts.
// All outputs are registered and reflect bus activity one cycle later; the checker observes only and never stalls the bus.
module wb_itr_chk #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int SEL_WIDTH = 2,
    parameter int MAX_OUTST = 4,
    parameter int TO_WIDTH  = 8,
    parameter int STALL_TO  = 16,
    parameter int ACK_TO    = 64,
    localparam int CNT_WIDTH = $clog2(MAX_OUTST + 1)
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 sync_rst_i,
    input  logic                 clr_i,
    input  logic                 itr_cyc_i,
    input  logic                 itr_stb_i,
    input  logic                 itr_we_i,
    input  logic [SEL_WIDTH-1:0] itr_sel_i,
    input  logic [ADR_WIDTH-1:0] itr_adr_i,
    input  logic [DAT_WIDTH-1:0] itr_dat_i,
    input  logic                 itr_ack_o,
    input  logic                 itr_err_o,
    input  logic                 itr_rty_o,
    input  logic                 itr_stall_o,
    output logic [CNT_WIDTH-1:0] outst_o,
    output logic                 busy_o,
    output logic [7:0]           viol_o,
    output logic                 irq_o
);

    localparam logic [CNT_WIDTH-1:0] OUTST_MAX = CNT_WIDTH'(MAX_OUTST);
    localparam bit                   STALL_EN  = (STALL_TO != 0);
    localparam bit                   ACK_EN    = (ACK_TO != 0);
    localparam logic [TO_WIDTH-1:0]  STALL_LIM = TO_WIDTH'(STALL_TO - 1);
    localparam logic [TO_WIDTH-1:0]  ACK_LIM   = TO_WIDTH'(ACK_TO - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    // Request attributes that must stay stable while a request is stalled.
    typedef struct packed {
        logic [ADR_WIDTH-1:0] adr;
        logic                 we;
        logic [SEL_WIDTH-1:0] sel;
        logic [DAT_WIDTH-1:0] dat;
    } req_t;

    state_t                state_q;
    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  outst_q;
    logic [CNT_WIDTH-1:0]  outst_d;
    logic [7:0]            viol_q;
    logic [7:0]            evt;
    logic                  irq_q;
    logic [TO_WIDTH-1:0]   stall_cnt_q;
    logic                  stall_fired_q;
    logic [TO_WIDTH-1:0]   ack_cnt_q;
    logic                  ack_fired_q;
    logic                  cap_vld_q;
    req_t                  cap_q;
    req_t                  cur_req;

    logic req;
    logic term;
    logic multi;
    logic stalled;
    logic ack_run;

    assign req     = itr_cyc_i & itr_stb_i & ~itr_stall_o;
    assign term    = itr_ack_o | itr_err_o | itr_rty_o;
    assign multi   = (itr_ack_o & itr_err_o) | (itr_ack_o & itr_rty_o) | (itr_err_o & itr_rty_o);
    assign stalled = itr_cyc_i & itr_stb_i & itr_stall_o;
    assign ack_run = itr_cyc_i & (outst_q != '0) & ~term;

    assign cur_req.adr = itr_adr_i;
    assign cur_req.we  = itr_we_i;
    assign cur_req.sel = itr_sel_i;
    assign cur_req.dat = itr_dat_i;

    // Dropping cyc aborts everything in flight; otherwise +req -term with saturation at both ends.
    always_comb begin
        outst_d = outst_q;
        if (!itr_cyc_i) begin
            outst_d = '0;
        end else if (req && !term) begin
            if (outst_q != OUTST_MAX) outst_d = outst_q + CNT_WIDTH'(1);
        end else if (term && !req) begin
            if (outst_q != '0) outst_d = outst_q - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        evt = '0;
        if (state_q == ST_RESET) begin
            evt[6] = itr_cyc_i | itr_stb_i;
        end else begin
            evt[0] = multi;
            evt[1] = term && (outst_q == '0) && !req;
            evt[2] = req && (outst_q == OUTST_MAX) && !term;
            evt[3] = !itr_cyc_i && (outst_q != '0);
            evt[4] = STALL_EN && stalled && !stall_fired_q && (stall_cnt_q == STALL_LIM);
            evt[5] = ACK_EN && ack_run && !ack_fired_q && (ack_cnt_q == ACK_LIM);
            // Data only matters for writes; a we change is caught on its own.
            evt[7] = cap_vld_q && (!itr_stb_i
                                   || (cur_req.adr != cap_q.adr)
                                   || (cur_req.we  != cap_q.we)
                                   || (cur_req.sel != cap_q.sel)
                                   || (cap_q.we && (cur_req.dat != cap_q.dat)));
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q       <= ST_RESET;
            busy_q        <= 1'b0;
            outst_q       <= '0;
            viol_q        <= '0;
            irq_q         <= 1'b0;
            stall_cnt_q   <= '0;
            stall_fired_q <= 1'b0;
            ack_cnt_q     <= '0;
            ack_fired_q   <= 1'b0;
            cap_vld_q     <= 1'b0;
            cap_q         <= '0;
        end else if (sync_rst_i) begin
            state_q       <= ST_RESET;
            busy_q        <= 1'b0;
            outst_q       <= '0;
            viol_q        <= '0;
            irq_q         <= 1'b0;
            stall_cnt_q   <= '0;
            stall_fired_q <= 1'b0;
            ack_cnt_q     <= '0;
            ack_fired_q   <= 1'b0;
            cap_vld_q     <= 1'b0;
            cap_q         <= '0;
        end else begin
            // A new event in the same cycle as clr_i still lands.
            viol_q <= (clr_i ? 8'h00 : viol_q) | evt;
            irq_q  <= clr_i ? 1'b0 : |viol_q;

            case (state_q)
                ST_RESET: begin
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                    outst_q       <= '0;
                    stall_cnt_q   <= '0;
                    stall_fired_q <= 1'b0;
                    ack_cnt_q     <= '0;
                    ack_fired_q   <= 1'b0;
                    cap_vld_q     <= 1'b0;
                end
                ST_IDLE, ST_BUSY: begin
                    if (itr_cyc_i) begin
                        state_q <= ST_BUSY;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    outst_q <= outst_d;

                    if (stalled) begin
                        if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + TO_WIDTH'(1);
                        if (evt[4]) stall_fired_q <= 1'b1;
                    end else begin
                        stall_cnt_q   <= '0;
                        stall_fired_q <= 1'b0;
                    end

                    if (ack_run) begin
                        if (ack_cnt_q != '1) ack_cnt_q <= ack_cnt_q + TO_WIDTH'(1);
                        if (evt[5]) ack_fired_q <= 1'b1;
                    end else begin
                        ack_cnt_q   <= '0;
                        ack_fired_q <= 1'b0;
                    end

                    cap_vld_q <= stalled;
                    cap_q     <= cur_req;
                end
                default: begin
                    state_q <= ST_RESET;
                    busy_q  <= 1'b0;
                    outst_q <= '0;
                end
            endcase
        end
    end

    assign outst_o = outst_q;
    assign busy_o  = busy_q;
    assign viol_o  = viol_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_wb_itr_chk.sv
// Directed bench for wb_itr_chk with hand-computed expectations.
module tb_wb_itr_chk;

    logic        clk_i = 1'b0;
    logic        async_rst_i;
    logic        sync_rst_i;
    logic        clr_i;
    logic        itr_cyc_i;
    logic        itr_stb_i;
    logic        itr_we_i;
    logic [1:0]  itr_sel_i;
    logic [15:0] itr_adr_i;
    logic [15:0] itr_dat_i;
    logic        itr_ack_o;
    logic        itr_err_o;
    logic        itr_rty_o;
    logic        itr_stall_o;
    logic [2:0]  outst_o;
    logic        busy_o;
    logic [7:0]  viol_o;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;

    wb_itr_chk #(
        .ADR_WIDTH(16), .DAT_WIDTH(16), .SEL_WIDTH(2), .MAX_OUTST(4),
        .TO_WIDTH(8), .STALL_TO(16), .ACK_TO(64)
    ) dut (
        .clk_i      (clk_i),
        .async_rst_i(async_rst_i),
        .sync_rst_i (sync_rst_i),
        .clr_i      (clr_i),
        .itr_cyc_i  (itr_cyc_i),
        .itr_stb_i  (itr_stb_i),
        .itr_we_i   (itr_we_i),
        .itr_sel_i  (itr_sel_i),
        .itr_adr_i  (itr_adr_i),
        .itr_dat_i  (itr_dat_i),
        .itr_ack_o  (itr_ack_o),
        .itr_err_o  (itr_err_o),
        .itr_rty_o  (itr_rty_o),
        .itr_stall_o(itr_stall_o),
        .outst_o    (outst_o),
        .busy_o     (busy_o),
        .viol_o     (viol_o),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        async_rst_i = 1'b1;
        sync_rst_i  = 1'b0;
        clr_i       = 1'b0;
        itr_cyc_i   = 1'b0;
        itr_stb_i   = 1'b0;
        itr_we_i    = 1'b0;
        itr_sel_i   = 2'b00;
        itr_adr_i   = 16'h0000;
        itr_dat_i   = 16'h0000;
        itr_ack_o   = 1'b0;
        itr_err_o   = 1'b0;
        itr_rty_o   = 1'b0;
        itr_stall_o = 1'b0;

        tick();
        tick();
        chk("rst_outst", 32'(outst_o), 32'd0);
        chk("rst_busy",  32'(busy_o),  32'd0);
        chk("rst_viol",  32'(viol_o),  32'd0);
        chk("rst_irq",   32'(irq_o),   32'd0);
        async_rst_i = 1'b0;
        tick();

        // Three back-to-back requests, then three acks.
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1; itr_we_i = 1'b1; itr_sel_i = 2'b11;
        itr_dat_i = 16'h1111; itr_adr_i = 16'h0010;
        tick(); chk("b2b_o1", 32'(outst_o), 32'd1); chk("b2b_busy", 32'(busy_o), 32'd1);
        itr_adr_i = 16'h0012;
        tick(); chk("b2b_o2", 32'(outst_o), 32'd2);
        itr_adr_i = 16'h0014;
        tick(); chk("b2b_o3", 32'(outst_o), 32'd3);
        itr_stb_i = 1'b0; itr_ack_o = 1'b1;
        tick(); chk("b2b_o4", 32'(outst_o), 32'd2);
        tick(); chk("b2b_o5", 32'(outst_o), 32'd1);
        tick(); chk("b2b_o6", 32'(outst_o), 32'd0);
        itr_ack_o = 1'b0;
        chk("b2b_viol", 32'(viol_o), 32'd0);
        itr_cyc_i = 1'b0;
        tick(); chk("b2b_idle", 32'(busy_o), 32'd0); chk("b2b_viol2", 32'(viol_o), 32'd0);

        // Overflow: five requests with MAX_OUTST=4.
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1; itr_we_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            itr_adr_i = 16'(i * 2);
            tick(); chk("ovf_cnt", 32'(outst_o), 32'(i + 1));
        end
        tick();
        chk("ovf_sat",  32'(outst_o), 32'd4);
        chk("ovf_viol", 32'(viol_o),  32'h04);
        chk("ovf_irq0", 32'(irq_o),   32'd0);
        itr_stb_i = 1'b0;
        tick(); chk("ovf_irq1", 32'(irq_o), 32'd1);
        itr_ack_o = 1'b1;
        repeat (4) tick();
        itr_ack_o = 1'b0;
        chk("ovf_drain", 32'(outst_o), 32'd0);
        chk("ovf_hold",  32'(viol_o),  32'h04);
        itr_cyc_i = 1'b0; clr_i = 1'b1;
        tick(); clr_i = 1'b0;
        chk("ovf_clr_viol", 32'(viol_o), 32'h00);
        chk("ovf_clr_irq",  32'(irq_o),  32'd0);
        tick(); chk("ovf_irq_stay", 32'(irq_o), 32'd0);

        // ack and err together with one request in flight.
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1;
        tick(); chk("mt_o1", 32'(outst_o), 32'd1);
        itr_stb_i = 1'b0; itr_ack_o = 1'b1; itr_err_o = 1'b1;
        tick(); itr_ack_o = 1'b0; itr_err_o = 1'b0;
        chk("mt_viol", 32'(viol_o), 32'h01);
        chk("mt_o0",   32'(outst_o), 32'd0);
        tick(); chk("mt_irq", 32'(irq_o), 32'd1);
        clr_i = 1'b1;
        tick(); clr_i = 1'b0;
        chk("mt_clr_viol", 32'(viol_o), 32'h00);
        chk("mt_clr_irq",  32'(irq_o),  32'd0);
        itr_cyc_i = 1'b0;
        tick();

        // Stalled request: timeout after 16 cycles, then address change.
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1; itr_stall_o = 1'b1; itr_we_i = 1'b0;
        itr_adr_i = 16'h0020;
        repeat (15) tick();
        chk("sto_pre", 32'(viol_o), 32'h00);
        tick(); chk("sto_fire", 32'(viol_o), 32'h10);
        itr_adr_i = 16'h0022;
        tick(); chk("schg", 32'(viol_o), 32'h90);
        itr_stall_o = 1'b0;
        tick(); chk("sto_acc", 32'(outst_o), 32'd1); chk("sto_hold", 32'(viol_o), 32'h90);
        itr_stb_i = 1'b0; itr_ack_o = 1'b1;
        tick(); itr_ack_o = 1'b0;
        chk("sto_o0", 32'(outst_o), 32'd0);
        itr_cyc_i = 1'b0; clr_i = 1'b1;
        tick(); clr_i = 1'b0;
        chk("sto_clr", 32'(viol_o), 32'h00);

        // Abort with two in flight, then a late ack.
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1;
        tick(); tick(); chk("ab_o2", 32'(outst_o), 32'd2);
        itr_cyc_i = 1'b0; itr_stb_i = 1'b0;
        tick();
        chk("ab_o0",   32'(outst_o), 32'd0);
        chk("ab_viol", 32'(viol_o),  32'h08);
        chk("ab_busy", 32'(busy_o),  32'd0);
        itr_ack_o = 1'b1;
        tick(); itr_ack_o = 1'b0;
        chk("spur_viol", 32'(viol_o), 32'h0A);

        // Async reset mid-burst, then activity while in RESET.
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1;
        repeat (3) tick();
        chk("ar_o3",  32'(outst_o), 32'd3);
        chk("ar_irq", 32'(irq_o),   32'd1);
        itr_stb_i = 1'b0;
        #2 async_rst_i = 1'b1;
        #1;
        chk("ar_outst", 32'(outst_o), 32'd0);
        chk("ar_busy",  32'(busy_o),  32'd0);
        chk("ar_viol",  32'(viol_o),  32'd0);
        chk("ar_irq0",  32'(irq_o),   32'd0);
        tick();
        async_rst_i = 1'b0;
        tick();
        chk("rstact_viol",  32'(viol_o),  32'h40);
        chk("rstact_outst", 32'(outst_o), 32'd0);
        tick();
        chk("rstact_irq",  32'(irq_o),  32'd1);
        chk("rstact_busy", 32'(busy_o), 32'd1);

        // Missing acknowledge: one request held 64 cycles without termination.
        clr_i = 1'b1;
        tick(); clr_i = 1'b0;
        chk("ato_clr", 32'(viol_o), 32'h00);
        itr_stb_i = 1'b1;
        tick(); itr_stb_i = 1'b0;
        chk("ato_o1", 32'(outst_o), 32'd1);
        repeat (63) tick();
        chk("ato_pre", 32'(viol_o), 32'h00);
        tick(); chk("ato_fire", 32'(viol_o), 32'h20);
        tick(); chk("ato_irq", 32'(irq_o), 32'd1);

        // Synchronous reset clears everything.
        itr_cyc_i = 1'b0; sync_rst_i = 1'b1;
        tick(); sync_rst_i = 1'b0;
        chk("sr_outst", 32'(outst_o), 32'd0);
        chk("sr_viol",  32'(viol_o),  32'd0);
        chk("sr_irq",   32'(irq_o),   32'd0);
        chk("sr_busy",  32'(busy_o),  32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
